// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, trap causes, status/enable bit positions and FSM states
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;
  localparam logic [31:0] MISA_VAL = 32'h4000_0100;
  typedef enum logic {S_RUN, S_REDIRECT} state_e;
endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter; a per-half write overrides that half's increment but keeps the carry
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);
  logic [63:0] cnt_q, cnt_d, sum;
  assign sum = cnt_q + {63'b0, inc_i};
  assign cnt_d = {wr_hi_i ? wdata_i : sum[63:32], wr_lo_i ? wdata_i : sum[31:0]};
  assign cnt_o = cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap/mret sequencer producing a one-cycle fetch redirect
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr_pc,
  input  logic [31:0] instr_bits,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_write,
  input  logic        csr_read,
  input  logic        csr_set,
  input  logic        csr_clear,
  input  logic        mret,
  input  logic        illegal_instruction,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);
  state_e state_q, state_d;
  logic mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d, mtie_q, mtie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d, rpc_q, rpc_d;
  logic [31:0] mstatus, mie_r, mip, old, new_val, cause, base, trap_pc;
  logic [63:0] cyc, ret;
  logic mapped, any_strobe, wr_en, csr_illegal, run_v, ext_take, tim_take;
  logic take_irq, take_ill, take_trap, take_mret, do_csr;
  assign mstatus = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign mie_r   = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
  assign mip     = {20'b0, ext_irq, 3'b0, timer_irq, 7'b0};
  always_comb begin
    mapped = 1'b1;
    old = '0;
    case (csr_addr)
      CSR_MSTATUS:   old = mstatus;
      CSR_MISA:      old = MISA_VAL;
      CSR_MIE:       old = mie_r;
      CSR_MTVEC:     old = mtvec_q;
      CSR_MSCRATCH:  old = mscratch_q;
      CSR_MEPC:      old = mepc_q;
      CSR_MCAUSE:    old = mcause_q;
      CSR_MTVAL:     old = mtval_q;
      CSR_MIP:       old = mip;
      CSR_MCYCLE:    old = cyc[31:0];
      CSR_MCYCLEH:   old = cyc[63:32];
      CSR_MINSTRET:  old = ret[31:0];
      CSR_MINSTRETH: old = ret[63:32];
      CSR_MHARTID:   old = HART_ID;
      default:       mapped = 1'b0;
    endcase
  end
  assign csr_rdata   = old;
  assign any_strobe  = csr_write | csr_read | csr_set | csr_clear;
  // set/clear with a zero operand is a pure read and must not trip the read-only check
  assign wr_en       = csr_write | ((csr_set | csr_clear) & |csr_wdata);
  assign new_val     = csr_write ? csr_wdata : csr_set ? (old | csr_wdata) : (old & ~csr_wdata);
  assign csr_illegal = any_strobe & (~mapped | (wr_en & &csr_addr[11:10]));
  assign run_v       = instr_valid & (state_q == S_RUN);
  assign ext_take    = mie_q & meie_q & ext_irq;
  assign tim_take    = mie_q & mtie_q & timer_irq;
  assign take_irq    = run_v & (ext_take | tim_take);
  assign take_ill    = run_v & ~(ext_take | tim_take) & (illegal_instruction | csr_illegal);
  assign take_trap   = take_irq | take_ill;
  assign take_mret   = run_v & ~take_trap & mret;
  assign do_csr      = run_v & ~take_trap & ~mret & wr_en;
  assign cause       = take_irq ? (ext_take ? CAUSE_MEI : CAUSE_MTI) : CAUSE_ILLEGAL;
  assign base        = mtvec_q & ~32'h3;
  assign trap_pc     = (take_irq && mtvec_q[1:0] == 2'b01) ? base + {26'b0, cause[3:0], 2'b00} : base;
  always_comb begin
    {mie_d, mpie_d, meie_d, mtie_d} = {mie_q, mpie_q, meie_q, mtie_q};
    {mtvec_d, mscratch_d, mepc_d, mcause_d, mtval_d} = {mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q};
    state_d = S_RUN;
    rpc_d = rpc_q;
    if (do_csr)
      case (csr_addr)
        CSR_MSTATUS:  {mpie_d, mie_d} = {new_val[MSTATUS_MPIE], new_val[MSTATUS_MIE]};
        CSR_MIE:      {meie_d, mtie_d} = {new_val[MIE_MEIE], new_val[MIE_MTIE]};
        CSR_MTVEC:    mtvec_d = new_val & ~32'h2;
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d = new_val & ~32'h3;
        CSR_MCAUSE:   mcause_d = new_val;
        CSR_MTVAL:    mtval_d = new_val;
        default: ;
      endcase
    if (take_trap) begin
      mepc_d = instr_pc & ~32'h3;
      mpie_d = mie_q;
      mie_d = 1'b0;
      mcause_d = cause;
      mtval_d = take_ill ? instr_bits : mtval_q;
      state_d = S_REDIRECT;
      rpc_d = trap_pc;
    end else if (take_mret) begin
      mie_d = mpie_q;
      mpie_d = 1'b1;
      state_d = S_REDIRECT;
      rpc_d = mepc_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_RUN;
      {mie_q, mpie_q, meie_q, mtie_q} <= '0;
      mtvec_q <= MTVEC_RESET & ~32'h2;
      {mscratch_q, mepc_q, mcause_q, mtval_q, rpc_q} <= '0;
    end else begin
      state_q <= state_d;
      {mie_q, mpie_q, meie_q, mtie_q} <= {mie_d, mpie_d, meie_d, mtie_d};
      {mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, rpc_q} <= {mtvec_d, mscratch_d, mepc_d, mcause_d, mtval_d, rpc_d};
    end
  assign redirect_valid = state_q == S_REDIRECT;
  assign busy = state_q == S_REDIRECT;
  assign redirect_pc = rpc_q;
  csr_counter64 u_mcycle (
    .clk(clk), .rst_n(rst_n), .inc_i(1'b1),
    .wr_lo_i(do_csr && csr_addr == CSR_MCYCLE), .wr_hi_i(do_csr && csr_addr == CSR_MCYCLEH),
    .wdata_i(new_val), .cnt_o(cyc)
  );
  csr_counter64 u_minstret (
    .clk(clk), .rst_n(rst_n), .inc_i(run_v & ~take_trap),
    .wr_lo_i(do_csr && csr_addr == CSR_MINSTRET), .wr_hi_i(do_csr && csr_addr == CSR_MINSTRETH),
    .wdata_i(new_val), .cnt_o(ret)
  );
endmodule
